// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data BRAM port b bundle between the memory stage and the BRAM
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  enb;
  logic [3:0]            web;
  logic [31:0]           dinb;
  logic [31:0]           doutb;

  modport master (output addrb, enb, web, dinb, input doutb);
  modport slave  (input addrb, enb, web, dinb, output doutb);
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV memory-access stage and MEM/WB pipeline register
module mem_access_unit #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             ALU_result,
  input  logic [31:0]             rs2_data,
  input  logic [31:0]             pc_imm,
  input  logic [31:0]             pc_4,
  input  logic [2:0]              funct3,
  input  logic [1:0]              RegSrc,
  input  logic [4:0]              rd,
  input  logic                    RegWrite,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  mem_access_unit_if.master       bram,
  output logic                    out_valid,
  output logic [31:0]             ALU_result_q,
  output logic [31:0]             pc_imm_q,
  output logic [31:0]             pc_4_q,
  output logic [31:0]             DMEM_word,
  output logic [2:0]              funct3_q,
  output logic [1:0]              RegSrc_q,
  output logic [4:0]              rd_q,
  output logic                    RegWrite_q,
  output logic                    misaligned
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  off;
  logic        accept;
  logic        load_done;
  logic        bad_width;
  logic        fault;
  logic [3:0]  store_mask;

  assign off    = ALU_result[1:0];
  assign accept = in_valid && in_ready;

  assign bram.addrb = ALU_result[ADDR_WIDTH+1:2];
  assign bram.dinb  = rs2_data << {off, 3'b000};

  // Classify the presented access: illegal width codes and unaligned halfword/word accesses fault
  always_comb begin
    bad_width  = 1'b0;
    store_mask = 4'b0000;
    if (MemRead)
      bad_width = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    if (MemWrite)
      bad_width = funct3[2] || (funct3[1:0] == 2'b11);
    fault = (MemRead || MemWrite) &&
            (bad_width ||
             ((funct3[1:0] == 2'b01) && off[0]) ||
             ((funct3[1:0] == 2'b10) && (off != 2'b00)));
    case (funct3[1:0])
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  end

  // Port b is only active in the accept cycle of a legal memory access
  always_comb begin
    bram.enb = 1'b0;
    bram.web = 4'b0000;
    if (accept && !fault && (MemRead || MemWrite)) begin
      bram.enb = 1'b1;
      if (MemWrite)
        bram.web = store_mask;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state: a legal load parks the stage until the BRAM read data is due
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && MemRead && !fault)
          state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (cnt == 2'd0) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency down-counter, preloaded while idle so it is ready on the first wait cycle
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 2'd0;
    else if (state == IDLE)
      cnt <= 2'(READ_LATENCY - 1);
    else if (cnt != 2'd0)
      cnt <= cnt - 2'd1;
  end

  // MEM/WB register: capture pass-through fields on accept, read data when the load completes
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      ALU_result_q <= '0;
      pc_imm_q     <= '0;
      pc_4_q       <= '0;
      DMEM_word    <= '0;
      funct3_q     <= '0;
      RegSrc_q     <= '0;
      rd_q         <= '0;
      RegWrite_q   <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        ALU_result_q <= ALU_result;
        pc_imm_q     <= pc_imm;
        pc_4_q       <= pc_4;
        funct3_q     <= funct3;
        RegSrc_q     <= RegSrc;
        rd_q         <= rd;
        RegWrite_q   <= RegWrite && !fault;
        misaligned   <= fault;
        DMEM_word    <= '0;
        out_valid    <= !(MemRead && !fault);
      end else if (load_done) begin
        DMEM_word <= bram.doutb;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit at read latency 1 and 3
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, RegWrite, MemRead, MemWrite;
  logic [31:0] ALU_result, rs2_data, pc_imm, pc_4;
  logic [2:0]  funct3;
  logic [1:0]  RegSrc;
  logic [4:0]  rd;

  logic        in_ready[2], out_valid[2], RegWrite_q[2], misaligned[2];
  logic [31:0] ALU_result_q[2], pc_imm_q[2], pc_4_q[2], DMEM_word[2];
  logic [2:0]  funct3_q[2];
  logic [1:0]  RegSrc_q[2];
  logic [4:0]  rd_q[2];
  logic        enb[2];
  logic [3:0]  web[2];
  logic [31:0] dinb[2];
  logic [11:0] addrb[2];

  mem_access_unit_if #(.ADDR_WIDTH(12)) bus0 ();
  mem_access_unit_if #(.ADDR_WIDTH(12)) bus1 ();

  mem_access_unit #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .ALU_result(ALU_result), .rs2_data(rs2_data), .pc_imm(pc_imm), .pc_4(pc_4),
    .funct3(funct3), .RegSrc(RegSrc), .rd(rd), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .bram(bus0.master),
    .out_valid(out_valid[0]), .ALU_result_q(ALU_result_q[0]), .pc_imm_q(pc_imm_q[0]),
    .pc_4_q(pc_4_q[0]), .DMEM_word(DMEM_word[0]), .funct3_q(funct3_q[0]),
    .RegSrc_q(RegSrc_q[0]), .rd_q(rd_q[0]), .RegWrite_q(RegWrite_q[0]), .misaligned(misaligned[0]));

  mem_access_unit #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .ALU_result(ALU_result), .rs2_data(rs2_data), .pc_imm(pc_imm), .pc_4(pc_4),
    .funct3(funct3), .RegSrc(RegSrc), .rd(rd), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .bram(bus1.master),
    .out_valid(out_valid[1]), .ALU_result_q(ALU_result_q[1]), .pc_imm_q(pc_imm_q[1]),
    .pc_4_q(pc_4_q[1]), .DMEM_word(DMEM_word[1]), .funct3_q(funct3_q[1]),
    .RegSrc_q(RegSrc_q[1]), .rd_q(rd_q[1]), .RegWrite_q(RegWrite_q[1]), .misaligned(misaligned[1]));

  assign enb[0] = bus0.enb;    assign enb[1] = bus1.enb;
  assign web[0] = bus0.web;    assign web[1] = bus1.web;
  assign dinb[0] = bus0.dinb;  assign dinb[1] = bus1.dinb;
  assign addrb[0] = bus0.addrb; assign addrb[1] = bus1.addrb;

  // BRAM models: byte-write memory, read pipeline of depth 1 and 3, garbage when not reading
  logic [31:0] init_img [0:255];
  logic [31:0] bram0 [0:255];
  logic [31:0] bram1 [0:255];
  logic [31:0] rdp0;
  logic [31:0] rdp1 [0:2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        bram0[i] <= init_img[i];
        bram1[i] <= init_img[i];
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus0.web[b]) bram0[bus0.addrb[7:0]][8*b +: 8] <= bus0.dinb[8*b +: 8];
        if (bus1.web[b]) bram1[bus1.addrb[7:0]][8*b +: 8] <= bus1.dinb[8*b +: 8];
      end
    end
    rdp0    <= (bus0.enb && bus0.web == 4'b0) ? bram0[bus0.addrb[7:0]] : $urandom;
    rdp1[0] <= (bus1.enb && bus1.web == 4'b0) ? bram1[bus1.addrb[7:0]] : $urandom;
    rdp1[1] <= rdp1[0];
    rdp1[2] <= rdp1[1];
  end
  assign bus0.doutb = rdp0;
  assign bus1.doutb = rdp1[2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          due0, due1;
    logic [31:0] alu, pci, pc4, dmem;
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic [4:0]  rdn;
    logic        rw, mis;
  } wb_t;
  wb_t exp_arr[$];
  logic [31:0] ref_mem [0:255];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    funct3 = 3'd0; RegSrc = 2'd0; rd = 5'd0;
    ALU_result = 32'd0; rs2_data = 32'd0; pc_imm = 32'd0; pc_4 = 32'd0;
  endtask

  task automatic drive(input logic rdop, input logic wrop, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic rw, input logic [4:0] rdn, input logic [1:0] rs);
    in_valid = 1'b1; MemRead = rdop; MemWrite = wrop; funct3 = f3; ALU_result = alu;
    rs2_data = rs2; RegWrite = rw; rd = rdn; RegSrc = rs; pc_imm = $urandom; pc_4 = $urandom;
  endtask

  // Access size in bytes from the ISA width code; 0 marks an illegal code
  function automatic int access_size(input logic rdop, input logic wrop, input logic [2:0] f3);
    if (rdop) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
    end
    if (wrop) begin
      if (f3 == 3'd0) return 1;
      if (f3 == 3'd1) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, out_valid[k]); end
      n_tests++; if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, in_ready[k]); end
      n_tests++; if (RegWrite_q[k] !== 1'b0 || misaligned[k] !== 1'b0) begin n_fail++; $display("FAIL reset_flags[%0d] got rw=%b mis=%b want 0 0", k, RegWrite_q[k], misaligned[k]); end
      n_tests++; if (DMEM_word[k] !== 32'd0 || ALU_result_q[k] !== 32'd0 || rd_q[k] !== 5'd0) begin n_fail++; $display("FAIL reset_bundle[%0d] got dmem=%h alu=%h rd=%0d want zeros", k, DMEM_word[k], ALU_result_q[k], rd_q[k]); end
      n_tests++; if (enb[k] !== 1'b0 || web[k] !== 4'b0) begin n_fail++; $display("FAIL reset_port[%0d] got enb=%b web=%b want 0 0000", k, enb[k], web[k]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sb();
    drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 1'b0, 5'd0, 2'd0);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (addrb[k] !== 12'h040 || web[k] !== 4'b1000 || enb[k] !== 1'b1) begin n_fail++; $display("FAIL sb_port[%0d] got addrb=%h web=%b enb=%b want 040 1000 1", k, addrb[k], web[k], enb[k]); end
      n_tests++; if (dinb[k] !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_dinb[%0d] got %h want ab000000", k, dinb[k]); end
    end
    tick();
    set_idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (out_valid[k] !== 1'b1 || misaligned[k] !== 1'b0 || DMEM_word[k] !== 32'd0) begin n_fail++; $display("FAIL sb_wb[%0d] got v=%b mis=%b dmem=%h want 1 0 0", k, out_valid[k], misaligned[k], DMEM_word[k]); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL sb_pulse[%0d] got %b want 0", k, out_valid[k]); end
    end
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 1'b1, 5'd5, 2'd1);
    #1;
    n_tests++; if (enb[0] !== 1'b1 || web[0] !== 4'b0 || addrb[0] !== 12'h080) begin n_fail++; $display("FAIL lw_port got enb=%b web=%b addrb=%h want 1 0000 080", enb[0], web[0], addrb[0]); end
    tick();
    set_idle();
    #1;
    n_tests++; if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL lw_wait got rdy=%b v=%b want 0 0", in_ready[0], out_valid[0]); end
    tick();
    n_tests++; if (out_valid[0] !== 1'b1 || DMEM_word[0] !== 32'hDEAD_BEEF || RegWrite_q[0] !== 1'b1 || rd_q[0] !== 5'd5) begin n_fail++; $display("FAIL lw_wb got v=%b dmem=%h rw=%b rd=%0d want 1 deadbeef 1 5", out_valid[0], DMEM_word[0], RegWrite_q[0], rd_q[0]); end
    tick();
    n_tests++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL lw3_early got %b want 0", out_valid[1]); end
    tick();
    n_tests++; if (out_valid[1] !== 1'b1 || DMEM_word[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw3_wb got v=%b dmem=%h want 1 deadbeef", out_valid[1], DMEM_word[1]); end
    tick();
  endtask

  task automatic test_misaligned_lh();
    drive(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 1'b1, 5'd7, 2'd1);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (enb[k] !== 1'b0 || web[k] !== 4'b0) begin n_fail++; $display("FAIL lh_port[%0d] got enb=%b web=%b want 0 0000", k, enb[k], web[k]); end
    end
    tick();
    set_idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (out_valid[k] !== 1'b1 || misaligned[k] !== 1'b1 || RegWrite_q[k] !== 1'b0 || DMEM_word[k] !== 32'd0) begin n_fail++; $display("FAIL lh_wb[%0d] got v=%b mis=%b rw=%b dmem=%h want 1 1 0 0", k, out_valid[k], misaligned[k], RegWrite_q[k], DMEM_word[k]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 3'b000, 32'(i), 32'd0, 1'b1, 5'(i), 2'd0);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] op %0d got %b want 1", k, i, in_ready[k]); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (out_valid[k] !== 1'b1 || ALU_result_q[k] !== 32'(i)) begin n_fail++; $display("FAIL b2b_wb[%0d] op %0d got v=%b alu=%h want 1 %h", k, i, out_valid[k], ALU_result_q[k], i); end
      end
    end
    set_idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_end[%0d] got %b want 0", k, out_valid[k]); end
    end
  endtask

  task automatic test_load_then_add();
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 1'b1, 5'd9, 2'd1);
    #1;
    n_tests++; if (enb[1] !== 1'b1) begin n_fail++; $display("FAIL la_enb got %b want 1", enb[1]); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h55, 32'd0, 1'b1, 5'd3, 2'd0);
    for (int t = 1; t <= 3; t++) begin
      #1;
      n_tests++; if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL la_wait T+%0d got rdy=%b v=%b want 0 0", t, in_ready[1], out_valid[1]); end
      tick();
    end
    n_tests++; if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b1 || DMEM_word[1] !== 32'hDEAD_BEEF || rd_q[1] !== 5'd9) begin n_fail++; $display("FAIL la_load_wb got rdy=%b v=%b dmem=%h rd=%0d want 1 1 deadbeef 9", in_ready[1], out_valid[1], DMEM_word[1], rd_q[1]); end
    tick();
    set_idle();
    n_tests++; if (out_valid[1] !== 1'b1 || ALU_result_q[1] !== 32'h55 || rd_q[1] !== 5'd3 || DMEM_word[1] !== 32'd0) begin n_fail++; $display("FAIL la_add_wb got v=%b alu=%h rd=%0d dmem=%h want 1 55 3 0", out_valid[1], ALU_result_q[1], rd_q[1], DMEM_word[1]); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_load();
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 1'b1, 5'd4, 2'd1);
    tick();
    set_idle();
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rml_T1 got v=%b want 0", out_valid[1]); end
    tick();
    rst = 1'b0;
    n_tests++; if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || DMEM_word[1] !== 32'd0) begin n_fail++; $display("FAIL rml_T2 got rdy=%b v=%b dmem=%h want 1 0 0", in_ready[1], out_valid[1], DMEM_word[1]); end
    for (int t = 3; t <= 5; t++) begin
      tick();
      n_tests++; if (out_valid[1] !== 1'b0 || DMEM_word[1] !== 32'd0) begin n_fail++; $display("FAIL rml_T%0d got v=%b dmem=%h want 0 0", t, out_valid[1], DMEM_word[1]); end
    end
  endtask

  task automatic test_random();
    int head[2];
    wb_t e;
    int due, size, offi, w;
    logic ld, st, flt, issue;
    logic [3:0] m;
    head[0] = 0;
    head[1] = 0;
    exp_arr.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];
    for (int c = 0; c < 420; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] === 1'b1) begin
          n_tests++;
          if (head[k] >= exp_arr.size()) begin
            n_fail++; $display("FAIL rand_unexpected[%0d] cyc %0d got valid want idle", k, c);
          end else begin
            e = exp_arr[head[k]];
            due = (k == 0) ? e.due0 : e.due1;
            if (due != c || ALU_result_q[k] !== e.alu || pc_imm_q[k] !== e.pci || pc_4_q[k] !== e.pc4 ||
                DMEM_word[k] !== e.dmem || funct3_q[k] !== e.f3 || RegSrc_q[k] !== e.rs || rd_q[k] !== e.rdn ||
                RegWrite_q[k] !== e.rw || misaligned[k] !== e.mis) begin
              n_fail++;
              $display("FAIL rand_wb[%0d] cyc %0d got alu=%h dmem=%h rd=%0d rw=%b mis=%b want cyc %0d alu=%h dmem=%h rd=%0d rw=%b mis=%b",
                       k, c, ALU_result_q[k], DMEM_word[k], rd_q[k], RegWrite_q[k], misaligned[k], due, e.alu, e.dmem, e.rdn, e.rw, e.mis);
            end
            head[k]++;
          end
        end else if (head[k] < exp_arr.size()) begin
          due = (k == 0) ? exp_arr[head[k]].due0 : exp_arr[head[k]].due1;
          n_tests++;
          if (due <= c) begin n_fail++; $display("FAIL rand_missing[%0d] cyc %0d got no valid want valid at %0d", k, c, due); head[k]++; end
        end
      end
      issue = (c < 400) && in_ready[0] && in_ready[1] && ($urandom_range(0, 3) != 0);
      if (issue) begin
        case ($urandom_range(0, 2))
          0:       begin ld = 1'b0; st = 1'b0; end
          1:       begin ld = 1'b1; st = 1'b0; end
          default: begin ld = 1'b0; st = 1'b1; end
        endcase
        drive(ld, st, 3'($urandom_range(0, 7)), (ld || st) ? 32'($urandom_range(0, 63)) : $urandom,
              $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        size = access_size(ld, st, funct3);
        offi = int'(ALU_result[1:0]);
        w    = int'(ALU_result[9:2]);
        flt  = (ld || st) && (size == 0 || (offi % size) != 0);
        m    = (st && !flt) ? 4'(((1 << size) - 1) << offi) : 4'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (enb[k] !== ((ld || st) && !flt) || web[k] !== m || addrb[k] !== 12'(ALU_result >> 2) ||
              (m != 4'b0 && dinb[k] !== (rs2_data << (8 * offi)))) begin
            n_fail++;
            $display("FAIL rand_port[%0d] cyc %0d got enb=%b web=%b addrb=%h dinb=%h want enb=%b web=%b addrb=%h",
                     k, c, enb[k], web[k], addrb[k], dinb[k], (ld || st) && !flt, m, 12'(ALU_result >> 2));
          end
        end
        e.alu = ALU_result; e.pci = pc_imm; e.pc4 = pc_4; e.f3 = funct3; e.rs = RegSrc; e.rdn = rd;
        e.rw = RegWrite && !flt; e.mis = flt;
        e.dmem = (ld && !flt) ? ref_mem[w] : 32'd0;
        e.due0 = c + 1 + ((ld && !flt) ? 1 : 0);
        e.due1 = c + 1 + ((ld && !flt) ? 3 : 0);
        exp_arr.push_back(e);
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_mem[w][8*b +: 8] = rs2_data[8*(b - offi) +: 8];
      end else begin
        set_idle();
        if ($urandom_range(0, 1) == 1) begin
          ALU_result = $urandom; MemWrite = 1'b1;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (enb[k] !== 1'b0 || web[k] !== 4'b0) begin n_fail++; $display("FAIL rand_quiet[%0d] cyc %0d got enb=%b web=%b want 0 0000", k, c, enb[k], web[k]); end
        end
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (head[k] != exp_arr.size()) begin n_fail++; $display("FAIL rand_drain[%0d] got %0d bundles want %0d", k, head[k], exp_arr.size()); end
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_img[i] = $urandom;
    init_img[8'h80] = 32'hDEAD_BEEF;
    set_idle();
    test_reset();
    test_sb();
    test_lw();
    test_misaligned_lh();
    test_back_to_back();
    test_load_then_add();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
